// File: rtl/fb_scanout_reader_pkg.sv
// Shared constants and types for the frame-buffer scanout read path.
// Pixel packing, request opcode and the FIFO entry layout live here.
package fb_scanout_reader_pkg;

  localparam int H_WORDS_DEF  = 80;
  localparam int V_LINES_DEF  = 480;
  localparam int ADDR_W       = 17;
  localparam int DATA_W       = 32;
  localparam int PIX_BITS     = 4;
  localparam int PIX_PER_WORD = 8;
  localparam int PIX_CNT_W    = 3;
  localparam int FIFO_W       = 34;

  localparam logic [3:0] RD_OP = 4'b0000;

  typedef struct packed {
    logic              frame_first;
    logic              line_last;
    logic [DATA_W-1:0] data;
  } fb_word_t;

endpackage

// File: rtl/fb_scanout_reader_pixel_unpacker.sv
// Turns 32-bit frame-buffer words into a 4-bit pixel stream, pixel 0 first,
// with start-of-frame and end-of-line markers; refills with no bubble.
module pixel_unpacker
  import fb_scanout_reader_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fifo_empty,
  input  fb_word_t            fifo_word,
  output logic                fifo_pop,
  output logic                word_done,
  output logic [PIX_BITS-1:0] out_pix,
  output logic                out_sof,
  output logic                out_eol,
  output logic                out_rts,
  input  logic                out_rtr
);

  logic [DATA_W-1:0]    shift_q, shift_d;
  logic [PIX_CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic                 valid_q, valid_d;
  logic                 line_last_q, line_last_d;
  logic                 sof_q, sof_d;
  logic                 eol_q, eol_d;
  logic                 consume, last_pix;

  assign out_pix = shift_q[PIX_BITS-1:0];
  assign out_sof = sof_q;
  assign out_eol = eol_q;
  assign out_rts = valid_q;

  always_comb begin
    consume     = valid_q && out_rtr;
    last_pix    = (pix_cnt_q == PIX_CNT_W'(PIX_PER_WORD-1));
    word_done   = consume && last_pix;
    fifo_pop    = !fifo_empty && (!valid_q || word_done);
    shift_d     = shift_q;
    pix_cnt_d   = pix_cnt_q;
    valid_d     = valid_q;
    line_last_d = line_last_q;
    sof_d       = sof_q;
    eol_d       = eol_q;
    if (fifo_pop) begin
      shift_d     = fifo_word.data;
      pix_cnt_d   = '0;
      valid_d     = 1'b1;
      line_last_d = fifo_word.line_last;
      sof_d       = fifo_word.frame_first;
      eol_d       = 1'b0;
    end else if (consume) begin
      shift_d   = shift_q >> PIX_BITS;
      pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
      sof_d     = 1'b0;
      // Marker is precomputed for the pixel about to be presented.
      eol_d     = line_last_q && (pix_cnt_q == PIX_CNT_W'(PIX_PER_WORD-2));
      if (last_pix) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      pix_cnt_q   <= '0;
      valid_q     <= 1'b0;
      line_last_q <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      pix_cnt_q   <= pix_cnt_d;
      valid_q     <= valid_d;
      line_last_q <= line_last_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
    end
  end

endmodule

// File: rtl/fifo.sv
// Generic synchronous FIFO with first-word-fall-through read data.
// Push while full and pop while empty are ignored.
module fifo #(
  parameter int WIDTH     = 34,
  parameter int DEPTH     = 8,
  parameter int LOG2DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [LOG2DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG2DEPTH:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign full  = (count_q == (LOG2DEPTH+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LOG2DEPTH'(DEPTH-1)) ? '0 : wr_ptr_q + LOG2DEPTH'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LOG2DEPTH'(DEPTH-1)) ? '0 : rd_ptr_q + LOG2DEPTH'(1);
    end
    count_d = count_q + (LOG2DEPTH+1)'(do_push) - (LOG2DEPTH+1)'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/fb_scanout_reader.sv
// Frame-buffer scanout engine: raster-order word fetch through the arbiter,
// word FIFO, and pixel unpacker feeding the display stage.
module fb_scanout_reader
  import fb_scanout_reader_pkg::*;
#(
  parameter int                H_WORDS        = H_WORDS_DEF,
  parameter int                V_LINES        = V_LINES_DEF,
  parameter logic [ADDR_W-1:0] FB_BASE        = 17'h00000,
  parameter int                FIFO_DEPTH     = 8,
  parameter int                FIFO_LOG2DEPTH = 3
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                enable,
  output logic                arb_rts,
  input  logic                arb_rtr,
  output logic [ADDR_W-1:0]   arb_addr_out,
  output logic [3:0]          wr_op,
  output logic [DATA_W-1:0]   arb_data_out,
  input  logic                bcast_xfc,
  input  logic [DATA_W-1:0]   arb_data_in,
  output logic [PIX_BITS-1:0] out_pix,
  output logic                out_sof,
  output logic                out_eol,
  output logic                out_rts,
  input  logic                out_rtr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam int TOTAL_WORDS = H_WORDS * V_LINES;
  localparam int COL_W       = $clog2(H_WORDS + 1);
  localparam int WORDS_W     = FIFO_LOG2DEPTH + 1;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [WORDS_W-1:0] words_q, words_d;
  logic              arb_rts_q, arb_rts_d;
  logic              push, frame_last, line_last, has_space;
  logic              fifo_full, fifo_empty, fifo_pop, word_done;
  fb_word_t          push_word, head_word;

  assign arb_rts      = arb_rts_q;
  assign arb_addr_out = addr_q;
  assign wr_op        = RD_OP;
  assign arb_data_out = '0;

  always_comb begin
    frame_last = (word_idx_q == ADDR_W'(TOTAL_WORDS-1));
    line_last  = (col_q == COL_W'(H_WORDS-1));
    push       = (state_q == ST_WAIT) && bcast_xfc && !fifo_full;

    push_word.frame_first = (word_idx_q == '0);
    push_word.line_last   = line_last;
    push_word.data        = arb_data_in;

    // Occupancy counts the word held in the unpacker as well as the FIFO.
    words_d   = words_q + WORDS_W'(push) - WORDS_W'(word_done);
    has_space = (words_d < WORDS_W'(FIFO_DEPTH));

    state_d    = state_q;
    word_idx_d = word_idx_q;
    col_d      = col_q;
    case (state_q)
      ST_IDLE: begin
        // A frame in progress is finished even if enable has dropped.
        if ((enable || word_idx_q != '0) && has_space) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (arb_rtr) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (push) begin
          word_idx_d = frame_last ? '0 : word_idx_q + ADDR_W'(1);
          col_d      = line_last ? '0 : col_q + COL_W'(1);
          state_d    = (has_space && !(frame_last && !enable)) ? ST_REQ : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    addr_d    = FB_BASE + word_idx_d;
    arb_rts_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      addr_q     <= FB_BASE;
      col_q      <= '0;
      words_q    <= '0;
      arb_rts_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      addr_q     <= addr_d;
      col_q      <= col_d;
      words_q    <= words_d;
      arb_rts_q  <= arb_rts_d;
    end
  end

  fifo #(
    .WIDTH     (FIFO_W),
    .DEPTH     (FIFO_DEPTH),
    .LOG2DEPTH (FIFO_LOG2DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_),
    .push  (push),
    .wdata (push_word),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .rdata (head_word),
    .empty (fifo_empty)
  );

  pixel_unpacker u_unpacker (
    .clk        (clk),
    .rst_n      (rst_),
    .fifo_empty (fifo_empty),
    .fifo_word  (head_word),
    .fifo_pop   (fifo_pop),
    .word_done  (word_done),
    .out_pix    (out_pix),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_rts    (out_rts),
    .out_rtr    (out_rtr)
  );

endmodule

// File: doc/fb_scanout_reader.md
# fb_scanout_reader

Frame-buffer read engine: the read-side counterpart of the line-drawing write path. It walks the frame buffer in raster order, fetches 32-bit words through the shared memory arbiter, and buffers them in a small word FIFO. It then unpacks each word into eight 4-bit pixels and streams them out with start-of-frame and end-of-line markers for the display timing/colour stage.

## Interface
Parameters:
- H_WORDS, 80: words per line (640 px / 8).
- V_LINES, 480: lines per frame.
- FB_BASE, 17'h00000: word address of pixel (0,0).
- FIFO_DEPTH, 8: word FIFO entries.
- FIFO_LOG2DEPTH, 3: log2 of FIFO_DEPTH.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_  in  1  reset, asynchronous, active-low.
- enable  in  1  level; high = fetch frames continuously.
- arb_rts  out  1  read request valid.
- arb_rtr  in  1  arbiter accepts request.
- arb_addr_out  out  17  word address of request.
- wr_op  out  4  byte-write mask; constant 4'b0000 (read).
- arb_data_out  out  32  constant 0.
- bcast_xfc  in  1  read data valid on arb_data_in.
- arb_data_in  in  32  returned word.
- out_pix  out  4  pixel value.
- out_sof  out  1  pixel is (0,0) of a frame.
- out_eol  out  1  pixel is last of its line.
- out_rts  out  1  pixel valid.
- out_rtr  in  1  downstream ready.

## Operation
- Pixel packing: word holds pixels 0..7 of an 8-pixel span; pixel i = bits [4i+3:4i]; pixel 0 emitted first.
- Address: arb_addr_out = FB_BASE + word_idx, where word_idx runs 0 .. H_WORDS*V_LINES-1 (38399 by default) and then wraps to 0. The adder is 17-bit; overflow is not checked.
- Request FSM states and transitions:
  - IDLE → REQ when enable && fifo_count < FIFO_DEPTH. If enable is low, stay in IDLE with word_idx = 0.
  - REQ: arb_rts = 1; address held stable. On arb_rts && arb_rtr → WAIT.
  - WAIT: at most one read outstanding. On bcast_xfc:
    - push {frame_first, line_last, arb_data_in} (34 bits) into the FIFO;
    - advance word_idx.
    - Next state: REQ if space remains and the frame is not ending with enable low; otherwise IDLE.
  - bcast_xfc outside WAIT is ignored.
- Flags on each pushed word:
  - frame_first = (word_idx == 0);
  - line_last = (word_idx mod H_WORDS == H_WORDS-1), tracked with a column counter rather than a divider.
- Enable deassert mid-frame: the current frame is fetched to completion, then the FSM returns to IDLE with word_idx = 0. Re-assert restarts at (0,0).
- Unpacker:
  - Pops a word when empty, or when the last pixel is consumed in the same cycle (no bubble between words).
  - Shifts right by 4 on each out_rts && out_rtr; a 3-bit pixel counter tracks position in the word.
  - out_sof = frame_first && pix_cnt == 0; out_eol = line_last && pix_cnt == 7.
- FIFO full: no request is issued. The credit check at IDLE guarantees a push never overflows.
- FIFO empty: out_rts stays low; no pixel is invented.

## Timing
- Reset values: arb_rts = 0, arb_addr_out = FB_BASE, wr_op = 0, arb_data_out = 0, out_rts = 0, out_pix = 0, out_sof = 0, out_eol = 0. FSM = IDLE, word_idx = 0, FIFO empty.
- Reset mid-operation clears everything; an in-flight return that arrives after reset is ignored.
- arb_rts rises 1 cycle after enable is sampled high in IDLE.
- Back-to-back fetch: bcast_xfc in cycle N → next arb_rts in cycle N+1 (if space).
- Return to output: word pushed at the edge ending cycle N (bcast_xfc) → first out_rts in cycle N+2.
- Throughput: up to one pixel per cycle from a non-empty FIFO.
- Handshakes:
  - All outputs are registered.
  - out_pix/out_sof/out_eol are stable while out_rts && !out_rtr.
  - arb_addr_out is stable while arb_rts && !arb_rtr.

## Structure
- Shared defines include: H_WORDS/V_LINES defaults, PIX_BITS = 4, PIX_PER_WORD = 8, RD_OP = 4'b0000, FIFO entry width 34.
- Word buffer: instance of the team's existing generic fifo (width 34, FIFO_DEPTH, FIFO_LOG2DEPTH), with its occupancy exposed or mirrored by a local counter.
- One natural sub-module: pixel_unpacker (word → pixel stream with sof/eol); the request FSM stays in the top.

## Test plan
- Reset then enable = 1, arb_rtr = 1, bcast_xfc 2 cycles after each accept, arb_data_in = 32'h76543210 → arb_addr_out 0,1,2…; pixels 0,1,…,7 per word; first pixel out_sof = 1.
- H_WORDS = 2, V_LINES = 2: out_eol on pixels 15 and 31 only; after word 3, arb_addr_out wraps to FB_BASE and out_sof reasserts.
- out_rtr = 0 for 100 cycles: exactly 8 words fetched, then arb_rts stays 0. Release out_rtr → fetching resumes; no word lost or duplicated.
- arb_rtr low 5 cycles during REQ: arb_rts and arb_addr_out are held stable; spurious bcast_xfc in IDLE/REQ is not pushed.
- enable dropped at word 10 of a 4-word frame (H_WORDS = 2, V_LINES = 2): fetch continues to word 11 (end of frame), then IDLE.
- rst_ asserted in WAIT with one read outstanding: outputs go to reset values immediately; a late bcast_xfc is ignored; re-enable fetches FB_BASE.
